// File: rtl/sdram_line_xfer.sv
// Cache-line transfer engine: splits a line into SDRAM bursts on write-back and
// reassembles SDRAM beats into a line on refill, with a per-transaction timeout.
module sdram_line_xfer #(
    parameter int LINE_BITS  = 128,
    parameter int SDRAM_WORD = 16,
    parameter int ADDR_W     = 24,
    parameter int TIMEOUT    = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [LINE_BITS-1:0]  req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [LINE_BITS-1:0]  resp_rdata,
    output logic                  sd_cmd_valid,
    input  logic                  sd_cmd_ready,
    output logic                  sd_cmd_write,
    output logic [ADDR_W-1:0]     sd_addr,
    output logic [SDRAM_WORD-1:0] sd_wdata,
    input  logic                  sd_wbeat_ready,
    input  logic [SDRAM_WORD-1:0] sd_rdata,
    input  logic                  sd_rbeat_valid
);
    localparam int BEATS = LINE_BITS / SDRAM_WORD;
    localparam int BW    = $clog2(BEATS);
    localparam int CW    = BW + 1;
    localparam int TW    = $clog2(TIMEOUT);
    localparam logic [CW-1:0]     LAST_BEAT  = CW'(BEATS - 1);
    localparam logic [TW-1:0]     TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BEATS - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WBURST, S_RBURST, S_DONE} state_t;

    state_t               r_state;
    logic                 r_req_ready;
    logic                 r_cmd_valid;
    logic                 r_cmd_write;
    logic [ADDR_W-1:0]    r_addr;
    logic [LINE_BITS-1:0] r_shift;
    logic [LINE_BITS-1:0] r_rdata;
    logic [CW-1:0]        r_beat;
    logic [TW-1:0]        r_tmo;
    logic                 r_resp_valid;
    logic                 r_resp_err;

    logic w_tmo_hit;
    logic w_wlast;
    logic w_rlast;

    assign w_tmo_hit = (r_tmo == TMO_LAST);
    assign w_wlast   = sd_wbeat_ready && (r_beat == LAST_BEAT);
    assign w_rlast   = sd_rbeat_valid && (r_beat == LAST_BEAT);

    assign req_ready    = r_req_ready;
    assign sd_cmd_valid = r_cmd_valid;
    assign sd_cmd_write = r_cmd_write;
    assign sd_addr      = r_addr;
    assign sd_wdata     = r_shift[LINE_BITS-1 -: SDRAM_WORD];
    assign resp_valid   = r_resp_valid;
    assign resp_err     = r_resp_err;
    assign resp_rdata   = r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_cmd_valid  <= 1'b0;
            r_cmd_write  <= 1'b0;
            r_addr       <= '0;
            r_shift      <= '0;
            r_rdata      <= '0;
            r_beat       <= '0;
            r_tmo        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_cmd_write <= req_write;
                        r_addr      <= req_addr & ALIGN_MASK;
                        r_shift     <= req_wdata;
                        r_beat      <= '0;
                        r_tmo       <= '0;
                        r_req_ready <= 1'b0;
                        r_cmd_valid <= 1'b1;
                        r_state     <= S_CMD;
                    end
                end
                S_CMD: begin
                    r_tmo <= r_tmo + TW'(1);
                    // No beat can complete here, so an expired timer always wins.
                    if (w_tmo_hit) begin
                        r_cmd_valid  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (sd_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= r_cmd_write ? S_WBURST : S_RBURST;
                    end
                end
                S_WBURST: begin
                    r_tmo <= r_tmo + TW'(1);
                    if (sd_wbeat_ready) begin
                        r_shift <= {r_shift[LINE_BITS-SDRAM_WORD-1:0], {SDRAM_WORD{1'b0}}};
                        r_beat  <= r_beat + CW'(1);
                    end
                    if (w_wlast || w_tmo_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= !w_wlast;
                        r_state      <= S_DONE;
                    end
                end
                S_RBURST: begin
                    r_tmo <= r_tmo + TW'(1);
                    if (sd_rbeat_valid) begin
                        r_rdata <= {r_rdata[LINE_BITS-SDRAM_WORD-1:0], sd_rdata};
                        r_beat  <= r_beat + CW'(1);
                    end
                    if (w_rlast || w_tmo_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= !w_rlast;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_cmd_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_line_xfer.sv
// Bench for sdram_line_xfer: a 128/16 instance (TIMEOUT 128) and a 256/32 instance
// (TIMEOUT 16) driven by an emulated SDRAM controller and a line-level model.
module tb_sdram_line_xfer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int sel    = 0;

    logic         req_valid = 1'b0, req_write = 1'b0;
    logic [23:0]  req_addr = '0;
    logic [255:0] req_wdata = '0;
    logic         sd_cmd_ready = 1'b0, sd_wbeat_ready = 1'b0, sd_rbeat_valid = 1'b0;
    logic [31:0]  sd_rdata = '0;
    logic         rv_a, rv_b;
    assign rv_a = req_valid && (sel == 0);
    assign rv_b = req_valid && (sel != 0);

    logic a_ready, a_rv, a_err, a_cv, a_cw;
    logic [127:0] a_rdata;
    logic [23:0]  a_addr;
    logic [15:0]  a_wdata;
    logic b_ready, b_rv, b_err, b_cv, b_cw;
    logic [255:0] b_rdata;
    logic [23:0]  b_addr;
    logic [31:0]  b_wdata;

    sdram_line_xfer #(.LINE_BITS(128), .SDRAM_WORD(16), .ADDR_W(24), .TIMEOUT(128)) u_a (
        .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(a_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata[127:0]), .resp_valid(a_rv), .resp_err(a_err),
        .resp_rdata(a_rdata), .sd_cmd_valid(a_cv), .sd_cmd_ready(sd_cmd_ready & (sel == 0)),
        .sd_cmd_write(a_cw), .sd_addr(a_addr), .sd_wdata(a_wdata), .sd_wbeat_ready(sd_wbeat_ready),
        .sd_rdata(sd_rdata[15:0]), .sd_rbeat_valid(sd_rbeat_valid));

    sdram_line_xfer #(.LINE_BITS(256), .SDRAM_WORD(32), .ADDR_W(24), .TIMEOUT(16)) u_b (
        .clk(clk), .rst(rst), .req_valid(rv_b), .req_ready(b_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(b_rv), .resp_err(b_err),
        .resp_rdata(b_rdata), .sd_cmd_valid(b_cv), .sd_cmd_ready(sd_cmd_ready & (sel != 0)),
        .sd_cmd_write(b_cw), .sd_addr(b_addr), .sd_wdata(b_wdata), .sd_wbeat_ready(sd_wbeat_ready),
        .sd_rdata(sd_rdata), .sd_rbeat_valid(sd_rbeat_valid));

    logic o_ready, o_rv, o_err, o_cv, o_cw;
    logic [255:0] o_rdata;
    logic [23:0]  o_addr;
    logic [31:0]  o_wdata;
    always_comb begin
        if (sel == 0) begin
            o_ready = a_ready; o_rv = a_rv; o_err = a_err; o_cv = a_cv; o_cw = a_cw;
            o_rdata = {128'b0, a_rdata}; o_addr = a_addr; o_wdata = {16'b0, a_wdata};
        end else begin
            o_ready = b_ready; o_rv = b_rv; o_err = b_err; o_cv = b_cv; o_cw = b_cw;
            o_rdata = b_rdata; o_addr = b_addr; o_wdata = b_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction against the emulated controller. Beats of the line go MSB
    // slice first; expected completion is one cycle after the 8th beat, or
    // TIMEOUT+1 cycles after acceptance when fewer beats are supplied.
    task automatic xfer(input string tag, input bit wr, input logic [23:0] addr,
                        input logic [255:0] wd, input int stall, input int gap,
                        input bit rnd_gap, input int give, input logic [31:0] base,
                        input int abort, output logic [255:0] rdat, output int rvc);
        int w, tmo, c, l, beats, stall_left, gap_left;
        logic [255:0] mask, bmask, exp_line, wdm;
        logic [31:0] rd;
        logic [23:0] exp_addr;
        bit fin, err;
        w = (sel != 0) ? 32 : 16;
        tmo = (sel != 0) ? 16 : 128;
        mask = (sel != 0) ? {256{1'b1}} : {128'b0, {128{1'b1}}};
        bmask = (sel != 0) ? 256'hFFFF_FFFF : 256'hFFFF;
        wdm = wd & mask;
        exp_addr = addr & ~24'd7;
        c = -1; l = -1; beats = 0; stall_left = stall; gap_left = 0;
        fin = 0; err = 0; rvc = -1; rdat = '0; exp_line = '0;
        chk({tag, "_idle_ready"}, 256'(o_ready), 256'(1));
        req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wdm;
        sd_cmd_ready = 0; sd_wbeat_ready = 1; sd_rbeat_valid = 1; sd_rdata = $urandom;
        step();
        req_valid = 0;
        for (int cyc = 1; cyc <= tmo + 4 && !fin; cyc++) begin
            if (abort > 0 && beats == abort) begin
                sd_wbeat_ready = 0; sd_rbeat_valid = 0; sd_cmd_ready = 0;
                #2 rst = 1;
                #1;
                chk({tag, "_rst_ready"}, 256'(o_ready), 256'(1));
                chk({tag, "_rst_cmdv"}, 256'(o_cv), 256'(0));
                chk({tag, "_rst_resp"}, 256'(o_rv), 256'(0));
                step();
                rst = 0;
                step();
                chk({tag, "_rst_noresp"}, 256'(o_rv), 256'(0));
                step();
                chk({tag, "_rst_noresp2"}, 256'(o_rv), 256'(0));
                return;
            end
            if (rvc < 0 && o_rv) begin
                rvc = cyc; err = o_err; rdat = o_rdata;
            end else if (rvc >= 0) begin
                chk({tag, "_pulse"}, 256'(o_rv), 256'(0));
                chk({tag, "_ready_again"}, 256'(o_ready), 256'(1));
                fin = 1;
            end
            if (!fin) begin
                chk({tag, "_busy"}, 256'(o_ready), 256'(0));
                chk({tag, "_addr"}, 256'(o_addr), 256'(exp_addr));
                chk({tag, "_cmdw"}, 256'(o_cw), 256'(wr));
                if (c < 0) begin
                    chk({tag, "_cmdv"}, 256'(o_cv), 256'(1));
                    sd_wbeat_ready = 1; sd_rbeat_valid = 1; sd_rdata = $urandom;
                    if (stall_left > 0) begin
                        sd_cmd_ready = 0;
                        stall_left--;
                    end else begin
                        sd_cmd_ready = 1;
                        c = cyc;
                    end
                end else begin
                    sd_cmd_ready = 0;
                    chk({tag, "_cmdv_low"}, 256'(o_cv), 256'(0));
                    if (rvc < 0 && beats < give && gap_left == 0) begin
                        sd_wbeat_ready = wr; sd_rbeat_valid = !wr;
                        rd = (base != 0) ? base + 32'(beats) : $urandom;
                        rd = rd & bmask[31:0];
                        sd_rdata = rd;
                        if (wr)
                            chk({tag, "_wbeat"}, 256'(o_wdata), (wdm >> (w * (7 - beats))) & bmask);
                        else
                            exp_line = ((exp_line << w) | 256'(rd)) & mask;
                        beats++;
                        if (beats == 8) l = cyc;
                        gap_left = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
                    end else begin
                        if (gap_left > 0) gap_left--;
                        sd_wbeat_ready = (beats == 8); sd_rbeat_valid = (beats == 8);
                        sd_rdata = $urandom;
                    end
                end
                step();
            end
        end
        sd_wbeat_ready = 0; sd_rbeat_valid = 0; sd_cmd_ready = 0;
        chk({tag, "_resp_cycle"}, 256'(rvc), (give >= 8) ? 256'(l + 1) : 256'(tmo + 1));
        chk({tag, "_resp_err"}, 256'(err), 256'(give < 8));
        if (!wr && give >= 8)
            chk({tag, "_rdata"}, rdat, exp_line);
    endtask

    logic [255:0] rd_line, rnd_line;
    int rvc;

    initial begin
        step();
        chk("rst_ready", 256'(o_ready), 256'(1));
        chk("rst_cmdv", 256'(o_cv), 256'(0));
        chk("rst_resp", 256'(o_rv), 256'(0));
        chk("rst_err", 256'(o_err), 256'(0));
        chk("rst_addr", 256'(o_addr), 256'(0));
        chk("rst_wdata", 256'(o_wdata), 256'(0));
        chk("rst_rdata", o_rdata, 256'(0));
        sel = 1;
        step();
        chk("rst_b_ready", 256'(o_ready), 256'(1));
        chk("rst_b_rdata", o_rdata, 256'(0));
        sel = 0;
        rst = 0;
        step();

        xfer("wb", 1, 24'h000123, 256'h0001_0002_0003_0004_0005_0006_0007_0008,
             0, 0, 0, 8, 0, 0, rd_line, rvc);
        chk("wb_latency", 256'(rvc), 256'(10));
        chk("wb_sdaddr_const", 256'(u_a.sd_addr), 256'h000120);

        xfer("refill", 0, 24'h00ABCD, '0, 0, 2, 0, 8, 32'hA0, 0, rd_line, rvc);
        chk("refill_line", rd_line, 256'h00A0_00A1_00A2_00A3_00A4_00A5_00A6_00A7);

        xfer("stall_w", 1, 24'h0F0F0F, {8{$urandom}}, 5, 0, 0, 8, 0, 0, rd_line, rvc);
        xfer("stall_r", 0, 24'h3C3C3F, '0, 5, 1, 0, 8, 0, 0, rd_line, rvc);

        // Reset while the command is still being offered.
        req_valid = 1; req_write = 1; req_addr = 24'h000040;
        step();
        req_valid = 0; sd_cmd_ready = 0;
        chk("rcmd_cmdv", 256'(o_cv), 256'(1));
        step();
        #2 rst = 1;
        #1;
        chk("rcmd_cmdv_drop", 256'(o_cv), 256'(0));
        chk("rcmd_ready", 256'(o_ready), 256'(1));
        step();
        rst = 0;
        step();
        chk("rcmd_noresp", 256'(o_rv), 256'(0));

        xfer("rst_wb", 1, 24'h000200, {8{$urandom}}, 0, 0, 0, 8, 0, 4, rd_line, rvc);
        xfer("post_rst", 1, 24'h000300, {8{$urandom}}, 0, 0, 0, 8, 0, 0, rd_line, rvc);

        for (int i = 0; i < 8; i++) begin
            rnd_line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            xfer("rand_a", 1'($urandom), 24'($urandom), rnd_line, int'($urandom_range(3, 0)),
                 2, 1, 8, 0, 0, rd_line, rvc);
        end

        sel = 1;
        step();
        xfer("sweep_wb", 1, 24'h123457, {8{$urandom}}, 0, 0, 0, 8, 0, 0, rd_line, rvc);
        xfer("sweep_rf", 0, 24'h000008, '0, 0, 0, 0, 8, 32'h1, 0, rd_line, rvc);
        chk("sweep_line", rd_line,
            256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
        xfer("timeout", 0, 24'h000010, '0, 0, 0, 0, 3, 0, 0, rd_line, rvc);
        chk("timeout_cycle", 256'(rvc), 256'(17));
        xfer("post_tmo", 0, 24'h000018, '0, 1, 0, 0, 8, 0, 0, rd_line, rvc);
        for (int i = 0; i < 4; i++) begin
            rnd_line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            xfer("rand_b", 1'($urandom), 24'($urandom), rnd_line, int'($urandom_range(3, 0)),
                 0, 0, 8, 0, 0, rd_line, rvc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
